// File: rtl/hpm_snapshot_reader_pkg.sv
// ============================================================================
// Module   : hpm_snapshot_reader_pkg
// Purpose  : Shared types and constants for the HPM snapshot reader: the
//            sample record pushed into the output FIFO, the counter CSR base
//            addresses and the engine state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hpm_snapshot_reader_pkg;

    // Base CSR addresses of mhpmcounter3 and its upper half mhpmcounter3h.
    localparam logic [11:0] c_CSR_MHPM_COUNTER_3  = 12'hB03;
    localparam logic [11:0] c_CSR_MHPM_COUNTER_3H = 12'hB83;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
        logic        last;
    } hpm_sample_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_HI1 = 3'd1,
        ST_RD_LO  = 3'd2,
        ST_RD_HI2 = 3'd3,
        ST_CLR_LO = 3'd4,
        ST_CLR_HI = 3'd5,
        ST_PUSH   = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/hpm_snapshot_reader_fifo.sv
// ============================================================================
// Module   : hpm_snapshot_reader_fifo
// Purpose  : Sample buffer between the snapshot engine and the consumer.
//            Head entry is presented combinationally.
// Ports    : clk_i, rst_i       clock, async active-high reset (flushes)
//            push_i, data_i     write side; caller never pushes when full
//            pop_i, data_o      read side; pop ignored when empty
//            full_o, empty_o    occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpm_snapshot_reader_fifo
    import hpm_snapshot_reader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  hpm_sample_t data_i,
    input  logic        pop_i,
    output hpm_sample_t data_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int c_AW = $clog2(DEPTH);

    hpm_sample_t     r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            w_push;
    logic            w_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/hpm_snapshot_reader.sv
// ============================================================================
// Module   : hpm_snapshot_reader
// Purpose  : Master engine on the HPM counter file's CSR port. On a software
//            trigger or periodic timer it reads mhpmcounter3 upward, optionally
//            clears each counter, and streams the 64-bit values out through a
//            sample FIFO. The CSR file has priority on the shared port.
// Ports    : clk_i, rst_i            clock, async active-high reset
//            trigger_i, period_i     snapshot start pulse / timer period (0=off)
//            clear_en_i              clear counters after reading
//            csr_busy_i              CSR file owns the port this cycle
//            req_o addr_o we_o wdata_o rdata_i   counter port
//            sample_*                valid/ready sample stream
//            busy_o, dropped_o       status; dropped saturates at 255
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpm_snapshot_reader
    import hpm_snapshot_reader_pkg::*;
#(
    parameter int NUM_COUNTERS = 6,
    parameter int XLEN         = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            trigger_i,
    input  logic [31:0]     period_i,
    input  logic            clear_en_i,
    input  logic            csr_busy_i,
    output logic            req_o,
    output logic [11:0]     addr_o,
    output logic            we_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic [XLEN-1:0] rdata_i,
    output logic            sample_valid_o,
    input  logic            sample_ready_i,
    output logic [4:0]      sample_idx_o,
    output logic [63:0]     sample_data_o,
    output logic            sample_last_o,
    output logic            busy_o,
    output logic [7:0]      dropped_o
);

    localparam state_e c_FIRST_RD = (XLEN == 32) ? ST_RD_HI1 : ST_RD_LO;

    state_e      r_state;
    state_e      w_state_next;
    logic [4:0]  r_idx;
    logic        r_clear_en;
    logic [31:0] r_timer;
    logic [7:0]  r_dropped;
    logic [31:0] r_hi1;
    logic [31:0] r_lo;
    logic [63:0] r_value;

    logic [63:0] w_rdata64;
    logic        w_gnt;
    logic        w_timer_fire;
    logic        w_start_req;
    logic        w_last;
    logic        w_hi_match;
    logic [11:0] w_addr_off;
    logic        w_push;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    hpm_sample_t w_push_data;
    hpm_sample_t w_head;

    assign w_rdata64    = 64'(rdata_i);
    assign w_gnt        = req_o & ~csr_busy_i;
    assign w_timer_fire = (period_i != 32'd0) && (r_timer == 32'd1);
    // A coincident trigger and timer fire collapse into one start request.
    assign w_start_req  = trigger_i | w_timer_fire;
    assign w_last       = (r_idx == 5'(NUM_COUNTERS));
    assign w_hi_match   = (w_rdata64[31:0] == r_hi1);
    assign w_addr_off   = {7'd0, r_idx} - 12'd1;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_o        = 1'b0;
        we_o         = 1'b0;
        addr_o       = 12'd0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_req) w_state_next = c_FIRST_RD;
            end
            ST_RD_HI1: begin
                req_o  = 1'b1;
                addr_o = c_CSR_MHPM_COUNTER_3H + w_addr_off;
                if (!csr_busy_i) w_state_next = ST_RD_LO;
            end
            ST_RD_LO: begin
                req_o  = 1'b1;
                addr_o = c_CSR_MHPM_COUNTER_3 + w_addr_off;
                if (!csr_busy_i) begin
                    if (XLEN == 32)      w_state_next = ST_RD_HI2;
                    else if (r_clear_en) w_state_next = ST_CLR_LO;
                    else                 w_state_next = ST_PUSH;
                end
            end
            ST_RD_HI2: begin
                req_o  = 1'b1;
                addr_o = c_CSR_MHPM_COUNTER_3H + w_addr_off;
                if (!csr_busy_i) begin
                    // High half moved under us: low half may have wrapped, re-read it.
                    if (!w_hi_match)     w_state_next = ST_RD_LO;
                    else if (r_clear_en) w_state_next = ST_CLR_LO;
                    else                 w_state_next = ST_PUSH;
                end
            end
            ST_CLR_LO: begin
                req_o  = 1'b1;
                we_o   = 1'b1;
                addr_o = c_CSR_MHPM_COUNTER_3 + w_addr_off;
                if (!csr_busy_i) w_state_next = (XLEN == 32) ? ST_CLR_HI : ST_PUSH;
            end
            ST_CLR_HI: begin
                req_o  = 1'b1;
                we_o   = 1'b1;
                addr_o = c_CSR_MHPM_COUNTER_3H + w_addr_off;
                if (!csr_busy_i) w_state_next = ST_PUSH;
            end
            ST_PUSH: begin
                if (!w_fifo_full) begin
                    w_push       = 1'b1;
                    w_state_next = w_last ? ST_IDLE : c_FIRST_RD;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: index, captured halves, timer, drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx      <= '0;
            r_clear_en <= 1'b0;
            r_timer    <= '0;
            r_dropped  <= '0;
            r_hi1      <= '0;
            r_lo       <= '0;
            r_value    <= '0;
        end else begin
            // r_timer == 0 means stopped; the next nonzero period reloads it.
            if (period_i == 32'd0)
                r_timer <= '0;
            else if (r_timer == 32'd0 || r_timer == 32'd1)
                r_timer <= period_i;
            else
                r_timer <= r_timer - 32'd1;

            if (w_start_req) begin
                if (r_state == ST_IDLE) begin
                    r_idx      <= 5'd1;
                    r_clear_en <= clear_en_i;
                end else if (r_dropped != 8'hFF) begin
                    r_dropped  <= r_dropped + 8'd1;
                end
            end

            if (w_push && !w_last) r_idx <= r_idx + 5'd1;

            if (w_gnt) begin
                case (r_state)
                    ST_RD_HI1: r_hi1 <= w_rdata64[31:0];
                    ST_RD_LO: begin
                        if (XLEN == 32) r_lo    <= w_rdata64[31:0];
                        else            r_value <= w_rdata64;
                    end
                    ST_RD_HI2: begin
                        if (w_hi_match) r_value <= {r_hi1, r_lo};
                        else            r_hi1   <= w_rdata64[31:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer
    // ------------------------------------------------------------------
    assign w_push_data = '{idx: r_idx, data: r_value, last: w_last};

    hpm_snapshot_reader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_push_data),
        .pop_i   (sample_ready_i),
        .data_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign sample_valid_o = ~w_fifo_empty;
    assign sample_idx_o   = w_head.idx;
    assign sample_data_o  = w_head.data;
    assign sample_last_o  = w_head.last;
    assign wdata_o        = '0;
    assign busy_o         = (r_state != ST_IDLE);
    assign dropped_o      = r_dropped;

endmodule

`default_nettype wire
